// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: launches the CNN layer engines one after another.
// Each stage gets a one-cycle start pulse. The sequencer then waits for a rising
// edge on that stage's over line before it moves on. Each wait is bounded by a
// timeout. A run can be cancelled with abort. The busy length of the last clean
// run is reported on run_cycles.
module cnn_layer_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int STAGE_W    = 2,
  parameter int TIMEOUT    = 2000000,
  parameter int TO_W       = 21,
  parameter int CYC_W      = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_over,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [STAGE_W-1:0]    err_stage,
  output logic [STAGE_W-1:0]    cur_stage,
  output logic [CYC_W-1:0]      run_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FINISH,
    ST_ERROR
  } state_t;

  localparam logic [TO_W-1:0]    WAIT_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  state_t                  state;
  logic [NUM_STAGES-1:0]   over_hist;
  logic [TO_W-1:0]         wait_cnt;
  logic [CYC_W-1:0]        busy_cnt;
  logic                    over_edge;
  logic [STAGE_W-1:0]      next_stage;

  // Completion is a fresh rise on the awaited stage only; the history register
  // holds last cycle's sample of every over line
  assign over_edge  = stage_over[cur_stage] & ~over_hist[cur_stage];
  assign next_stage = cur_stage + STAGE_W'(1);

  // Sequencer state machine with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      over_hist   <= '0;
      wait_cnt    <= '0;
      busy_cnt    <= '0;
      stage_start <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_stage   <= '0;
      cur_stage   <= '0;
      run_cycles  <= '0;
    end else begin
      over_hist   <= stage_over;
      stage_start <= '0;
      done        <= 1'b0;

      if (busy && (busy_cnt != '1)) begin
        busy_cnt <= busy_cnt + CYC_W'(1);
      end

      unique case (state)
        ST_IDLE, ST_ERROR: begin
          if (run) begin
            state          <= ST_LAUNCH;
            cur_stage      <= '0;
            stage_start[0] <= 1'b1;
            error          <= 1'b0;
            err_stage      <= '0;
            busy           <= 1'b1;
            busy_cnt       <= CYC_W'(1);
          end
        end

        ST_LAUNCH: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end

        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (over_edge) begin
            if (cur_stage == LAST_STAGE) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else begin
              state                   <= ST_LAUNCH;
              cur_stage               <= next_stage;
              stage_start[next_stage] <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= ST_ERROR;
            error     <= 1'b1;
            err_stage <= cur_stage;
            busy      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
        end

        ST_FINISH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!abort) begin
            run_cycles <= busy_cnt;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb_cnn_layer_sequencer: directed runs with scoreboarded start/done/error/busy events.
module tb_cnn_layer_sequencer;

  localparam int NS      = 4;
  localparam int TIMEOUT = 16;

  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;
  localparam int K_BEND  = 3;

  typedef struct {
    int kind;
    int value;
    int aux;
    int errf;
    int cycle;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic [NS-1:0] stage_over;
  logic [NS-1:0] stage_start;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_stage;
  logic [1:0]    cur_stage;
  logic [23:0]   run_cycles;

  logic [NS-1:0] model_over = '0;
  logic [NS-1:0] spur = '0;
  int            resp_d = 10;
  bit            level_mode = 1'b0;
  int            silent_stage = -1;
  int            cnt [NS];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   busy_len = 0;
  logic prev_busy = 1'b0;
  logic prev_error = 1'b0;

  assign stage_over = model_over | spur;

  cnn_layer_sequencer #(
    .NUM_STAGES(NS),
    .STAGE_W(2),
    .TIMEOUT(TIMEOUT),
    .TO_W(5),
    .CYC_W(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .abort(abort),
    .stage_over(stage_over),
    .stage_start(stage_start),
    .busy(busy),
    .done(done),
    .error(error),
    .err_stage(err_stage),
    .cur_stage(cur_stage),
    .run_cycles(run_cycles)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index: value seen at a negedge names the cycle after that posedge
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kindName(input int k);
    case (k)
      K_START: return "start";
      K_DONE:  return "done";
      K_ERR:   return "error";
      default: return "busy_end";
    endcase
  endfunction

  function automatic void pushExp(input int kind, input int value, input int aux,
                                  input int errf, input int cycle);
    exp_t e;
    e.kind = kind; e.value = value; e.aux = aux; e.errf = errf; e.cycle = cycle;
    sb.push_back(e);
  endfunction

  task automatic checkOutput(input int kind, input int val, input int aux, input int errf);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected %s @cyc %0d: got val=%0d aux=%0d err=%0d, required no event",
               kindName(kind), cyc, val, aux, errf);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.value != val || e.aux != aux || e.errf != errf || e.cycle != cyc) begin
        errors++;
        $display("[TB] FAIL %s: got %s val=%0d aux=%0d err=%0d cyc=%0d, required %s val=%0d aux=%0d err=%0d cyc=%0d",
                 kindName(e.kind), kindName(kind), val, aux, errf, cyc,
                 kindName(e.kind), e.value, e.aux, e.errf, e.cycle);
      end
    end
  endtask

  // Stage engine models: pulse or level response D cycles after each start
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (stage_start[i]) begin
        if (level_mode) model_over[i] = 1'b0;
        cnt[i] = (i == silent_stage) ? 0 : resp_d;
      end else if (cnt[i] > 0) begin
        cnt[i] = cnt[i] - 1;
        if (cnt[i] == 0) model_over[i] = 1'b1;
      end else if (!level_mode) begin
        model_over[i] = 1'b0;
      end
    end
  end

  // Monitor: turns observed output activity into events and scores them
  always @(negedge clk) begin
    if (!rst) begin
      if (stage_start != '0)
        checkOutput(K_START, int'(stage_start), int'(cur_stage), int'(error));
      if (done)
        checkOutput(K_DONE, 1, int'(busy), int'(error));
      if (error && !prev_error)
        checkOutput(K_ERR, int'(err_stage), int'(done), int'(error));
      if (busy) busy_len = prev_busy ? busy_len + 1 : 1;
      if (prev_busy && !busy)
        checkOutput(K_BEND, busy_len, int'(run_cycles), int'(error));
      prev_busy  = busy;
      prev_error = error;
    end
  end

  // One run request with hand-computed busy length and run_cycles
  task automatic applyStimulus(input int d, input bit lvl, input int silent,
                               input int abort_at, input int spur_at,
                               input int exp_len, input int exp_rc, input bit exp_err);
    int r;
    resp_d       = d;
    level_mode   = lvl;
    silent_stage = silent;
    @(negedge clk);
    run = 1'b1;
    r = cyc + 1;
    for (int k = 0; k < NS; k++) begin
      pushExp(K_START, 1 << k, k, 0, r + k * (d + 1));
      if (k == silent) begin
        pushExp(K_ERR, k, 0, 1, r + k * (d + 1) + TIMEOUT + 1);
        break;
      end
      if (abort_at >= 0 && abort_at < (k + 1) * (d + 1)) break;
      if (k == NS - 1) pushExp(K_DONE, 1, 1, 0, r + NS * (d + 1));
    end
    pushExp(K_BEND, exp_len, exp_rc, int'(exp_err), r + exp_len);
    @(negedge clk);
    run = 1'b0;
    for (int n = 0; n < exp_len + 3; n++) begin
      abort = (n == abort_at);
      spur  = (n == spur_at) ? 4'b1000 : 4'b0000;
      @(negedge clk);
    end
    abort = 1'b0;
    spur  = '0;
    silent_stage = -1;
  endtask

  // run held high: back-to-back runs with one idle cycle between them
  task automatic applyBackToBack(input int d, input int hold, input int nruns,
                                 input int exp_len);
    int r;
    resp_d     = d;
    level_mode = 1'b0;
    @(negedge clk);
    run = 1'b1;
    r = cyc + 1;
    for (int j = 0; j < nruns; j++) begin
      for (int k = 0; k < NS; k++)
        pushExp(K_START, 1 << k, k, 0, r + j * (exp_len + 1) + k * (d + 1));
      pushExp(K_DONE, 1, 1, 0, r + j * (exp_len + 1) + NS * (d + 1));
      pushExp(K_BEND, exp_len, exp_len, 0, r + j * (exp_len + 1) + exp_len);
    end
    repeat (hold) @(negedge clk);
    run = 1'b0;
    repeat (exp_len + 10) @(negedge clk);
  endtask

  // Directed test sequence
  initial begin
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset and idle");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({stage_start, busy, done, error, err_stage, cur_stage, run_cycles} != '0) begin
        errors++;
        $display("[TB] FAIL idle_outputs @cyc %0d: got start=%b busy=%b done=%b err=%b es=%0d cs=%0d rc=%0d, required all 0",
                 cyc, stage_start, busy, done, error, err_stage, cur_stage, run_cycles);
      end
    end

    $display("[TB] pulse stages D=10");
    applyStimulus(10, 1'b0, -1, -1, -1, 45, 45, 1'b0);

    $display("[TB] level stages D=3 with spurious over[3] during stage 1");
    applyStimulus(3, 1'b1, -1, -1, 5, 17, 17, 1'b0);

    $display("[TB] stage 2 silent -> timeout");
    applyStimulus(2, 1'b0, 2, -1, -1, 23, 17, 1'b1);

    $display("[TB] rerun after timeout");
    applyStimulus(2, 1'b0, -1, -1, -1, 13, 13, 1'b0);

    $display("[TB] abort in stage 1 wait together with its over edge");
    applyStimulus(10, 1'b0, -1, 21, -1, 22, 13, 1'b0);

    $display("[TB] run held for 100 cycles, D=5");
    applyBackToBack(5, 100, 4, 25);

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_events: got %0d unmet expected events, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
Top-level scheduler for the CNN inference pipeline. On a single run request it launches the layer engines (conv1, pool1, conv2, fc) in order: it pulses each stage's start, waits for that stage's over edge, then moves to the next stage. It also guards each stage with a timeout, supports abort, and reports total run latency. It drives the conv1_start/conv1_over-style handshake of every layer block.

Parameters:
NUM_STAGES, 4, number of sequenced layer engines; stage 0 runs first.
STAGE_W, 2, width of the stage index; must be at least $clog2(NUM_STAGES).
TIMEOUT, 2000000, maximum WAIT cycles allowed per stage before error.
TO_W, 21, width of the wait counter; must hold TIMEOUT-1.
CYC_W, 24, width of the run-cycle counter; saturates at all-ones.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
run  in  1  request a full inference; sampled each cycle.
abort  in  1  cancel the run in progress.
stage_over  in  NUM_STAGES  per-stage completion; may be a pulse or a level.
stage_start  out  NUM_STAGES  one-hot, one-cycle start pulse to a stage.
busy  out  1  high while a run is in progress.
done  out  1  one-cycle pulse when the last stage completes.
error  out  1  sticky flag set by a stage timeout.
err_stage  out  STAGE_W  index of the stage that timed out.
cur_stage  out  STAGE_W  index of the stage currently launched or awaited.
run_cycles  out  CYC_W  busy-cycle count of the last successful run.

Behaviour:
- Reset (rst high at an edge): state IDLE; all outputs 0; internal counters 0; over-history register 0.
- All outputs are registered. Cycle n means the interval after clock edge n.
- States: IDLE, LAUNCH, WAIT, FINISH, ERROR.
- IDLE/ERROR + run=1: next state LAUNCH with cur_stage=0. This clears error and err_stage, and loads the busy counter with 1.
- run while busy: ignored.
- LAUNCH: stage_start[cur_stage]=1 for exactly this cycle; wait counter cleared. Next state is always WAIT.
- WAIT:
  - Completion is a rising edge of stage_over[cur_stage], meaning current sample 1 and previous-cycle sample 0.
  - Edges during LAUNCH and edges on non-current stages are ignored.
  - The history register samples stage_over every cycle in every state.
  - On a detected edge: if cur_stage < NUM_STAGES-1, go to LAUNCH with cur_stage+1; otherwise go to FINISH.
  - If there is no edge and the wait counter equals TIMEOUT-1: go to ERROR with error=1 and err_stage=cur_stage. So a stage is allowed at most TIMEOUT WAIT cycles.
  - If an edge and the timeout occur in the same cycle, the edge wins.
- FINISH: done=1 for one cycle; run_cycles latches the busy count including this cycle. Next state IDLE.
- busy=1 in LAUNCH, WAIT and FINISH; 0 in IDLE and ERROR. The busy counter increments every busy cycle and saturates.
- abort=1 in LAUNCH, WAIT or FINISH:
  - Next state is IDLE, with no done and no run_cycles update. error is unchanged.
  - stage_start is 0 in the following cycle.
  - abort has priority over edge and timeout detection. abort in IDLE or ERROR has no effect.
- rst mid-run: immediate return to reset values at that edge.
- Timing contract: a stage whose over rises D≥1 cycles after its start cycle causes the next start exactly D+1 cycles after the previous start. Busy length is NUM_STAGES*(D+1)+1.
- A stage holding over high from a previous run must drop it before re-asserting. Otherwise no edge is seen and the stage times out.

Test Plan:
- Reset then idle 20 cycles -> all outputs 0, no stage_start activity.
- run pulse; each stage model pulses over 10 cycles after its start -> stage_start[0..3] pulsed in order, 11 cycles apart; done one cycle; busy high 45 cycles; run_cycles=45; error=0.
- Stages as level models: over held high until the next start, then dropped, with D=3 -> completes normally with run_cycles=17. Also inject a spurious stage_over[3] pulse during stage 1 -> ignored, and the sequence is unchanged.
- TIMEOUT=16; stage 2 never responds -> error=1, err_stage=2 exactly 16 WAIT cycles after start[2]; busy=0; no done. A subsequent run clears error and completes.
- abort asserted during stage 1 WAIT, together with a stage_over[1] edge in the same cycle -> IDLE next cycle, no start[2], no done, run_cycles unchanged from the previous run.
- run held high continuously for 100 cycles with D=5 -> back-to-back runs, each busy for 25 cycles with one IDLE cycle between runs, and a done pulse per run.
